// File: rtl/wb_io_mux_wdt_if.sv
// Wishbone IO bus bundle for wb_io_mux_wdt: master-side request/response, packed slave ports, timeout status.
// Modport "slave" is the mux's own view; modport "master" is the view of the core and peripherals around it.
interface wb_io_mux_wdt_if #(
   parameter int NUM_SLAVES = 4
);
   logic [31:0]              wbm_adr_i;
   logic [31:0]              wbm_dat_i;
   logic [3:0]               wbm_sel_i;
   logic                     wbm_we_i;
   logic                     wbm_cyc_i;
   logic                     wbm_stb_i;
   logic [2:0]               wbm_cti_i;
   logic [1:0]               wbm_bte_i;
   logic [31:0]              wbm_dat_o;
   logic                     wbm_ack_o;
   logic                     wbm_err_o;
   logic                     wbm_rty_o;

   logic [32*NUM_SLAVES-1:0] wbs_adr_o;
   logic [32*NUM_SLAVES-1:0] wbs_dat_o;
   logic [4*NUM_SLAVES-1:0]  wbs_sel_o;
   logic [3*NUM_SLAVES-1:0]  wbs_cti_o;
   logic [2*NUM_SLAVES-1:0]  wbs_bte_o;
   logic [NUM_SLAVES-1:0]    wbs_we_o;
   logic [NUM_SLAVES-1:0]    wbs_cyc_o;
   logic [NUM_SLAVES-1:0]    wbs_stb_o;
   logic [32*NUM_SLAVES-1:0] wbs_dat_i;
   logic [NUM_SLAVES-1:0]    wbs_ack_i;
   logic [NUM_SLAVES-1:0]    wbs_err_i;
   logic [NUM_SLAVES-1:0]    wbs_rty_i;

   logic                     to_event_o;
   logic [31:0]              to_addr_o;
   logic [15:0]              to_count_o;

   modport slave (
      input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
      output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
      output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_cti_o, wbs_bte_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
      input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
      output to_event_o, to_addr_o, to_count_o
   );

   modport master (
      output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
      input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
      input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_cti_o, wbs_bte_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
      output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
      input  to_event_o, to_addr_o, to_count_o
   );
endinterface

// File: rtl/wb_io_mux_wdt.sv
// Wishbone B3 classic 1-to-N IO mux with registered decode, decode-error response and, when
// WB_MUX_TIMEOUT_EN is defined, a per-transaction watchdog with timeout status outputs.
module wb_io_mux_wdt #(
   parameter int                       NUM_SLAVES     = 4,
   parameter logic [32*NUM_SLAVES-1:0] MATCH_ADDR     = {32'h00002000, 32'h00001040,
                                                         32'h00001000, 32'h00000000},
   parameter logic [32*NUM_SLAVES-1:0] MATCH_MASK     = {32'hfffff000, 32'hffffffc0,
                                                         32'hffffffc0, 32'hfffff000},
   parameter int                       TIMEOUT_CYCLES = 255
) (
   input  logic           wb_clk_i,
   input  logic           wb_rst_i,
   wb_io_mux_wdt_if.slave bus
);
   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   if (NUM_SLAVES < 1 || NUM_SLAVES > 32) begin : g_bad_num_slaves
      $error("wb_io_mux_wdt: NUM_SLAVES must be in 1..32");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("wb_io_mux_wdt: TIMEOUT_CYCLES must be in 1..65535");
   end

`ifdef WB_MUX_TIMEOUT_EN
   typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DERR = 2'd2, TOERR = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DERR = 2'd2} state_t;
`endif

   state_t                 state_q;
   state_t                 state_d;
   logic [IDX_W-1:0]       sel_q;
   logic [IDX_W-1:0]       match_idx;
   logic                   hit;
   logic                   req;
   logic                   sel_ack;
   logic                   sel_err;
   logic                   sel_rty;
   logic                   sel_resp;
   logic [NUM_SLAVES-1:0]  slv_cyc;
   logic [NUM_SLAVES-1:0]  slv_stb;
   logic [31:0]            m_dat;
   logic                   m_ack;
   logic                   m_err;
   logic                   m_rty;

   assign bus.wbs_adr_o = {NUM_SLAVES{bus.wbm_adr_i}};
   assign bus.wbs_dat_o = {NUM_SLAVES{bus.wbm_dat_i}};
   assign bus.wbs_sel_o = {NUM_SLAVES{bus.wbm_sel_i}};
   assign bus.wbs_cti_o = {NUM_SLAVES{bus.wbm_cti_i}};
   assign bus.wbs_bte_o = {NUM_SLAVES{bus.wbm_bte_i}};
   assign bus.wbs_we_o  = {NUM_SLAVES{bus.wbm_we_i}};

   assign req = bus.wbm_cyc_i & bus.wbm_stb_i;

   // Scan downwards so the lowest matching index is the one left standing.
   always_comb begin
      hit       = 1'b0;
      match_idx = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((bus.wbm_adr_i & MATCH_MASK[32*i +: 32]) ==
             (MATCH_ADDR[32*i +: 32] & MATCH_MASK[32*i +: 32])) begin
            hit       = 1'b1;
            match_idx = IDX_W'(i);
         end
      end
   end

   assign sel_ack  = bus.wbs_ack_i[sel_q];
   assign sel_err  = bus.wbs_err_i[sel_q];
   assign sel_rty  = bus.wbs_rty_i[sel_q];
   assign sel_resp = sel_ack | sel_err | sel_rty;

`ifdef WB_MUX_TIMEOUT_EN
   localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      to_addr_q;
   logic [15:0]      to_count_q;
   logic             to_event;
`endif

   always_comb begin
      state_d = state_q;
      slv_cyc = '0;
      slv_stb = '0;
      m_dat   = '0;
      m_ack   = 1'b0;
      m_err   = 1'b0;
      m_rty   = 1'b0;
`ifdef WB_MUX_TIMEOUT_EN
      to_event = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (req) state_d = hit ? ACTIVE : DERR;
         end
         ACTIVE: begin
            // cyc is gated straight through so a master abort reaches the slave this cycle.
            slv_cyc[sel_q] = bus.wbm_cyc_i;
            slv_stb[sel_q] = bus.wbm_stb_i;
            m_dat          = bus.wbs_dat_i[32*sel_q +: 32];
            m_ack          = sel_ack;
            m_err          = sel_err;
            m_rty          = sel_rty;
            if (!bus.wbm_cyc_i || sel_resp) state_d = IDLE;
`ifdef WB_MUX_TIMEOUT_EN
            else if (cnt_q == CNT_LIMIT) state_d = TOERR;
`endif
         end
         DERR: begin
            m_err   = bus.wbm_cyc_i;
            state_d = IDLE;
         end
`ifdef WB_MUX_TIMEOUT_EN
         TOERR: begin
            m_err    = bus.wbm_cyc_i;
            to_event = bus.wbm_cyc_i;
            state_d  = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && req && hit) sel_q <= match_idx;
      end
   end

`ifdef WB_MUX_TIMEOUT_EN
   // Counter rests at zero outside ACTIVE, so each transfer starts a fresh budget.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         cnt_q <= '0;
      end else if (state_q == ACTIVE && !sel_resp) begin
         cnt_q <= cnt_q + 1'b1;
      end else begin
         cnt_q <= '0;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         to_addr_q  <= '0;
         to_count_q <= '0;
      end else if (to_event) begin
         to_addr_q <= bus.wbm_adr_i;
         if (to_count_q != 16'hffff) to_count_q <= to_count_q + 16'd1;
      end
   end

   assign bus.to_event_o = to_event;
   assign bus.to_addr_o  = to_addr_q;
   assign bus.to_count_o = to_count_q;
`else
   assign bus.to_event_o = 1'b0;
   assign bus.to_addr_o  = 32'd0;
   assign bus.to_count_o = 16'd0;
`endif

   assign bus.wbs_cyc_o = slv_cyc;
   assign bus.wbs_stb_o = slv_stb;
   assign bus.wbm_dat_o = m_dat;
   assign bus.wbm_ack_o = m_ack;
   assign bus.wbm_err_o = m_err;
   assign bus.wbm_rty_o = m_rty;
endmodule

// File: tb/tb_wb_io_mux_wdt.sv
// Self-checking bench for wb_io_mux_wdt: vector table, hand sequences for timeout/abort/reset,
// and randomized transfers against an address-map reference model.
module tb_wb_io_mux_wdt;
   localparam int NS = 4;
   localparam int TO = 255;
   localparam int MAXW = TO + 20;
   // Slave 2 overlaps slave 1 (0x1000-0x107f vs 0x1000-0x103f) so lowest-index priority is visible.
   localparam logic [32*NS-1:0] P_ADDR = {32'h00002000, 32'h00001000, 32'h00001000, 32'h00000000};
   localparam logic [32*NS-1:0] P_MASK = {32'hfffff000, 32'hffffff80, 32'hffffffc0, 32'hfffff000};
`ifdef WB_MUX_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_io_mux_wdt_if #(.NUM_SLAVES(NS)) bus ();

   wb_io_mux_wdt #(
      .NUM_SLAVES(NS), .MATCH_ADDR(P_ADDR), .MATCH_MASK(P_MASK), .TIMEOUT_CYCLES(TO)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus)
   );

   int total = 0;
   int bad = 0;

   logic [31:0] ref_base [NS];
   logic [31:0] ref_mask [NS];
   int          kind [NS];   // 0 never responds, 1 ack, 2 err, 3 rty
   int          wt [NS];
   logic [31:0] sdat [NS];
   logic [NS-1:0] force_ack = '0;
   int          scnt [NS];
   logic [NS-1:0] fire;

   logic [15:0] m_count = '0;
   logic [31:0] m_addr = '0;

   // Slave models: respond after wt[i] stb cycles with the configured kind.
   always_comb begin
      fire = '0;
      bus.wbs_ack_i = '0;
      bus.wbs_err_i = '0;
      bus.wbs_rty_i = '0;
      bus.wbs_dat_i = '0;
      for (int i = 0; i < NS; i++) begin
         fire[i] = bus.wbs_cyc_o[i] && bus.wbs_stb_o[i] && kind[i] != 0 && scnt[i] == wt[i];
         bus.wbs_ack_i[i] = (fire[i] && kind[i] == 1) || force_ack[i];
         bus.wbs_err_i[i] = fire[i] && kind[i] == 2;
         bus.wbs_rty_i[i] = fire[i] && kind[i] == 3;
         bus.wbs_dat_i[32*i +: 32] = sdat[i];
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < NS; i++) begin
         if (bus.wbs_stb_o[i] && !fire[i]) scnt[i] <= scnt[i] + 1;
         else scnt[i] <= 0;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int decode_ref(input logic [31:0] a);
      for (int i = 0; i < NS; i++)
         if ((a & ref_mask[i]) == (ref_base[i] & ref_mask[i])) return i;
      return -1;
   endfunction

   // Expected outcome of one transfer from the address map and slave behaviour; updates status model.
   task automatic predict(input logic [31:0] a, output int lat, output logic [2:0] rsp,
                          output logic [31:0] d, output logic [NS-1:0] m, output logic ev);
      int t;
      t = decode_ref(a);
      ev = 1'b0;
      if (t < 0) begin
         lat = 1; rsp = 3'b010; d = '0; m = '0;
      end else if (TO_EN && (kind[t] == 0 || wt[t] >= TO)) begin
         lat = TO + 1; rsp = 3'b010; d = '0; m = NS'(1) << t; ev = 1'b1;
         if (m_count != 16'hffff) m_count = m_count + 16'd1;
         m_addr = a;
      end else begin
         lat = 1 + wt[t];
         rsp = (kind[t] == 1) ? 3'b100 : (kind[t] == 2) ? 3'b010 : 3'b001;
         d = sdat[t]; m = NS'(1) << t;
      end
   endtask

   task automatic run_txn(input logic [31:0] a, input logic we, output int lat, output logic [2:0] rsp,
                          output logic [31:0] d, output logic [NS-1:0] m, output logic ev,
                          output logic [32*NS-1:0] badr);
      bit got;
      @(negedge clk);
      bus.wbm_adr_i = a; bus.wbm_we_i = we; bus.wbm_dat_i = $urandom();
      bus.wbm_sel_i = 4'hf; bus.wbm_cti_i = 3'd0; bus.wbm_bte_i = 2'd0;
      bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1;
      got = 1'b0; lat = -1; rsp = '0; d = '0; m = '0; ev = 1'b0; badr = '0;
      for (int k = 1; k <= MAXW && !got; k++) begin
         @(negedge clk);
         if (k == 1) badr = bus.wbs_adr_o;
         m |= bus.wbs_stb_o;
         if (bus.wbm_ack_o || bus.wbm_err_o || bus.wbm_rty_o) begin
            got = 1'b1; lat = k;
            rsp = {bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o};
            d = bus.wbm_dat_o; ev = bus.to_event_o;
         end
      end
      bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0;
   endtask

   task automatic apply(input string tag, input logic [31:0] a, input logic we, input int e_lat,
                        input logic [2:0] e_rsp, input logic [31:0] e_dat, input logic [NS-1:0] e_mask,
                        input logic e_ev);
      int lat; logic [2:0] rsp; logic [31:0] d; logic [NS-1:0] m; logic ev; logic [32*NS-1:0] badr;
      run_txn(a, we, lat, rsp, d, m, ev, badr);
      check({tag, ".lat"}, 64'(lat), 64'(e_lat));
      check({tag, ".resp"}, 64'(rsp), 64'(e_rsp));
      check({tag, ".dat"}, 64'(d), 64'(e_dat));
      check({tag, ".stbmask"}, 64'(m), 64'(e_mask));
      check({tag, ".to_event"}, 64'(ev), 64'(e_ev));
      check({tag, ".bcast_adr"}, 64'(badr == {NS{a}}), 64'd1);
      @(negedge clk);
      check({tag, ".to_count"}, 64'(bus.to_count_o), 64'(m_count));
      check({tag, ".to_addr"}, 64'(bus.to_addr_o), 64'(m_addr));
   endtask

   task automatic default_slaves();
      for (int i = 0; i < NS; i++) begin
         kind[i] = 1; wt[i] = 0; sdat[i] = 32'ha5a50000 | 32'(i);
      end
   endtask

   typedef struct {
      int          slv;
      logic [31:0] adr;
      logic        we;
      int          knd;
      int          w;
      logic [31:0] sd;
      int          e_lat;
      logic [2:0]  e_rsp;
      logic [31:0] e_dat;
      logic [NS-1:0] e_mask;
   } vec_t;

   vec_t vt [9];

   initial begin
      int lat; logic [2:0] rsp; logic [31:0] d; logic [NS-1:0] m; logic ev; logic [32*NS-1:0] badr;
      bit ok;

      ref_base = '{32'h00000000, 32'h00001000, 32'h00001000, 32'h00002000};
      ref_mask = '{32'hfffff000, 32'hffffffc0, 32'hffffff80, 32'hfffff000};
      default_slaves();

      vt[0] = '{2, 32'h00001044, 1'b0, 1, 0, 32'hdeadbeef, 1, 3'b100, 32'hdeadbeef, 4'b0100};
      vt[1] = '{0, 32'h00003000, 1'b1, 1, 0, 32'h12345678, 1, 3'b010, 32'h00000000, 4'b0000};
      vt[2] = '{0, 32'h00000010, 1'b1, 1, 3, 32'h11111111, 4, 3'b100, 32'h11111111, 4'b0001};
      vt[3] = '{1, 32'h0000103c, 1'b0, 2, 1, 32'h22222222, 2, 3'b010, 32'h22222222, 4'b0010};
      vt[4] = '{3, 32'h00002ffc, 1'b0, 3, 0, 32'h33333333, 1, 3'b001, 32'h33333333, 4'b1000};
      vt[5] = '{1, 32'h00001000, 1'b0, 1, TO-1, 32'h44444444, TO, 3'b100, 32'h44444444, 4'b0010};
      vt[6] = '{0, 32'h00000fff, 1'b0, 1, 2, 32'h55555555, 3, 3'b100, 32'h55555555, 4'b0001};
      vt[7] = '{2, 32'h00001080, 1'b0, 1, 0, 32'h66666666, 1, 3'b010, 32'h00000000, 4'b0000};
      vt[8] = '{2, 32'h0000107f, 1'b0, 1, 0, 32'h77777777, 1, 3'b100, 32'h77777777, 4'b0100};

      // Reset with a request pending: nothing may reach a slave.
      bus.wbm_adr_i = 32'h00001044; bus.wbm_dat_i = '0; bus.wbm_sel_i = 4'hf; bus.wbm_we_i = 1'b0;
      bus.wbm_cti_i = '0; bus.wbm_bte_i = '0; bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1;
      repeat (3) @(negedge clk);
      check("rst.cyc", 64'(bus.wbs_cyc_o), 64'd0);
      check("rst.stb", 64'(bus.wbs_stb_o), 64'd0);
      check("rst.resp", 64'({bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o}), 64'd0);
      check("rst.dat", 64'(bus.wbm_dat_o), 64'd0);
      check("rst.status", 64'({bus.to_event_o, bus.to_addr_o, bus.to_count_o}), 64'd0);
      bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0;
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         default_slaves();
         kind[vt[i].slv] = vt[i].knd; wt[vt[i].slv] = vt[i].w; sdat[vt[i].slv] = vt[i].sd;
         apply($sformatf("vec%0d", i), vt[i].adr, vt[i].we, vt[i].e_lat, vt[i].e_rsp,
               vt[i].e_dat, vt[i].e_mask, 1'b0);
      end

      // Back-to-back beats with stb held: second beat re-decoded to slave 3, acked two cycles later.
      default_slaves();
      sdat[3] = 32'hcafef00d;
      @(negedge clk);
      bus.wbm_adr_i = 32'h00001044; bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1;
      @(negedge clk);
      check("b2b.ack1", 64'({bus.wbm_ack_o, bus.wbs_stb_o}), 64'({1'b1, 4'b0100}));
      bus.wbm_adr_i = 32'h00002004;
      @(negedge clk);
      check("b2b.gap", 64'({bus.wbm_ack_o, bus.wbm_err_o, bus.wbs_stb_o}), 64'd0);
      @(negedge clk);
      check("b2b.ack2", 64'({bus.wbm_ack_o, bus.wbs_stb_o}), 64'({1'b1, 4'b1000}));
      check("b2b.dat2", 64'(bus.wbm_dat_o), 64'h00000000cafef00d);
      bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0;
      @(negedge clk);

      // Slave 0 never answers.
      default_slaves();
      kind[0] = 0;
      bus.wbm_adr_i = 32'h00000010; bus.wbm_we_i = 1'b1; bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1;
      if (TO_EN) begin
         ok = 1'b1;
         for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (bus.wbs_stb_o !== 4'b0001 || bus.wbm_err_o !== 1'b0) ok = 1'b0;
         end
         check("to.window", 64'(ok), 64'd1);
         @(negedge clk);
         force_ack = 4'b0001;
         #1;
         check("to.err", 64'(bus.wbm_err_o), 64'd1);
         check("to.late_ack", 64'(bus.wbm_ack_o), 64'd0);
         check("to.event", 64'(bus.to_event_o), 64'd1);
         check("to.stb", 64'(bus.wbs_stb_o), 64'd0);
         @(negedge clk);
         force_ack = '0;
         bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0;
         m_count = m_count + 16'd1; m_addr = 32'h00000010;
         check("to.count", 64'(bus.to_count_o), 64'(m_count));
         check("to.addr", 64'(bus.to_addr_o), 64'(m_addr));
         check("to.event_once", 64'({bus.to_event_o, bus.wbm_err_o, bus.wbm_ack_o}), 64'd0);
      end else begin
         ok = 1'b1;
         for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (bus.wbs_stb_o !== 4'b0001 || bus.wbm_err_o !== 1'b0 || bus.to_event_o !== 1'b0 ||
                bus.to_count_o !== 16'd0 || bus.to_addr_o !== 32'd0) ok = 1'b0;
         end
         check("nowdt.held", 64'(ok), 64'd1);
         bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0;
         #1;
         check("nowdt.abort_cyc", 64'(bus.wbs_cyc_o), 64'd0);
         @(negedge clk);
      end

      // Master abort after 10 wait cycles.
      default_slaves();
      kind[1] = 0;
      bus.wbm_adr_i = 32'h00001000; bus.wbm_we_i = 1'b0; bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1;
      ok = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         if (bus.wbs_cyc_o !== 4'b0010 || bus.wbm_err_o !== 1'b0) ok = 1'b0;
      end
      check("abort.wait", 64'(ok), 64'd1);
      bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0;
      #1;
      check("abort.cyc_now", 64'(bus.wbs_cyc_o), 64'd0);
      @(negedge clk);
      check("abort.noerr", 64'({bus.wbm_err_o, bus.to_event_o, bus.wbs_cyc_o}), 64'd0);
      check("abort.count", 64'(bus.to_count_o), 64'(m_count));
      default_slaves();
      sdat[2] = 32'h0badf00d;
      apply("abort.next", 32'h00001050, 1'b0, 1, 3'b100, 32'h0badf00d, 4'b0100, 1'b0);

      // Randomized transfers against the reference model.
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a; int s; int r; int e_lat; logic [2:0] e_rsp; logic [31:0] e_dat;
         logic [NS-1:0] e_mask; logic e_ev;
         for (int i = 0; i < NS; i++) begin
            kind[i] = (TO_EN && $urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 3));
            r = $urandom_range(0, 19);
            wt[i] = (r < 16) ? int'($urandom_range(0, 4)) : (r < 18) ? TO - 1 : (TO_EN ? TO : 2);
            sdat[i] = $urandom();
         end
         s = $urandom_range(0, 5);
         if (s < 4) a = ref_base[s] | ($urandom() & ~ref_mask[s]);
         else if (s == 4) a = $urandom();
         else a = 32'h00003000 | ($urandom() & 32'h00000fff);
         predict(a, e_lat, e_rsp, e_dat, e_mask, e_ev);
         apply($sformatf("rnd%0d", n), a, 1'($urandom_range(0, 1)), e_lat, e_rsp, e_dat, e_mask, e_ev);
      end

      // Reset in the middle of an ACTIVE transfer.
      default_slaves();
      kind[3] = 0;
      @(negedge clk);
      bus.wbm_adr_i = 32'h00002000; bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1;
      repeat (5) @(negedge clk);
      check("midrst.active", 64'(bus.wbs_cyc_o), 64'b1000);
      rst = 1'b1;
      #1;
      m_count = '0; m_addr = '0;
      check("midrst.cyc", 64'({bus.wbs_cyc_o, bus.wbs_stb_o}), 64'd0);
      check("midrst.resp", 64'({bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o, bus.wbm_dat_o}), 64'd0);
      check("midrst.status", 64'({bus.to_event_o, bus.to_addr_o, bus.to_count_o}), 64'd0);
      bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      default_slaves();
      sdat[0] = 32'h600dcafe;
      apply("postrst", 32'h00000004, 1'b0, 1, 3'b100, 32'h600dcafe, 4'b0001, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
